// File: rtl/dsd_sp_fifo_if.sv
// ---------------------------------------------------------------------------
// dsd_sp_fifo_if
// Bundles the streaming ports and the single-port RAM pins of dsd_sp_fifo.
//
// Streaming input : in_valid, in_data, in_ready
// Streaming output: out_valid, out_data, out_ready
// Status          : level (words held: RAM + prefetch buffer + in-flight read)
// RAM pins        : ram_wen, ram_addr, ram_wdata (driven by the FIFO),
//                   ram_rdata (returned by the RAM one cycle after the address)
//
// Modports:
//   slave  - the FIFO controller itself
//   master - the surrounding environment (producer, consumer and RAM)
// ---------------------------------------------------------------------------
interface dsd_sp_fifo_if #(
   parameter int AW = 10,
   parameter int DW = 18
);

   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;

   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   logic [AW:0]   level;

   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready,
      output level,
      output ram_wen,
      output ram_addr,
      output ram_wdata,
      input  ram_rdata
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready,
      input  level,
      input  ram_wen,
      input  ram_addr,
      input  ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/dsd_sp_fifo.sv
// ---------------------------------------------------------------------------
// dsd_sp_fifo
// Streaming FIFO built on one single-port 2^AW x DW RAM. The RAM takes one
// access per cycle, so writes and reads are arbitrated; under contention they
// strictly alternate. A 2-entry prefetch buffer in front of the output hides
// the RAM's one-cycle read latency, giving a total capacity of 2^AW + 2 words.
//
// Ports:
//   mclk   - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   flush  - synchronous clear of all contents (wins over write and pop)
//   bus    - dsd_sp_fifo_if.slave: valid/ready input stream, valid/ready
//            output stream (registered), level, and the RAM pins
// ---------------------------------------------------------------------------
module dsd_sp_fifo #(
   parameter int AW = 10,
   parameter int DW = 18
) (
   input  logic          mclk,
   input  logic          rst,
   input  logic          flush,
   dsd_sp_fifo_if.slave  bus
);

   localparam logic [AW:0]   RAM_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   // RAM bookkeeping
   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [AW:0]   ram_cnt_q,  ram_cnt_d;
   logic          inflight_q, inflight_d;
   logic          last_wr_q,  last_wr_d;

   // Prefetch buffer; entry 0 is the head presented on out_data
   logic [1:0]    ob_cnt_q,    ob_cnt_d;
   logic [DW-1:0] ob0_q,       ob0_d;
   logic [DW-1:0] ob1_q,       ob1_d;
   logic          out_valid_q, out_valid_d;

   // Arbitration terms
   logic          pop;
   logic          rd_want;
   logic          in_ready;
   logic          wr_fire;
   logic          rd_fire;
   logic [2:0]    occ;
   logic [2:0]    occ_limit;

   // Arbitration between the single RAM port's two users.
   // A read is wanted when the RAM holds data and the buffer (counting the
   // word already on its way back, minus a word leaving this cycle) still has
   // room. The comparison is rewritten as occ < 2 + pop so it never underflows.
   // Writes normally win; a read wins only right after a write, which makes
   // the two strictly alternate when both are pending.
   always_comb begin
      pop       = out_valid_q && bus.out_ready;
      occ       = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
      occ_limit = 3'd2 + {2'b00, pop};
      rd_want   = (ram_cnt_q != '0) && (occ < occ_limit);
      in_ready  = !rst && !flush && (ram_cnt_q != RAM_FULL) && !(rd_want && last_wr_q);
      wr_fire   = bus.in_valid && in_ready;
      rd_fire   = rd_want && !wr_fire && !flush;
   end

   // RAM pins and outputs. When idle the address rests on rd_ptr.
   // level counts every word owned by the block, including the read in flight.
   assign bus.in_ready  = in_ready;
   assign bus.ram_wen   = wr_fire;
   assign bus.ram_addr  = wr_fire ? wr_ptr_q : rd_ptr_q;
   assign bus.ram_wdata = bus.in_data;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = ob0_q;
   assign bus.level     = ram_cnt_q
                        + {{(AW-1){1'b0}}, ob_cnt_q}
                        + {{AW{1'b0}}, inflight_q};

   // Next-state logic for pointers, counters and the prefetch buffer.
   // Flush clears all bookkeeping and drops any returning read data. The
   // buffer entries themselves are left alone; with ob_cnt at zero they are
   // dead and will be overwritten before they are ever shown.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ram_cnt_d   = ram_cnt_q;
      inflight_d  = inflight_q;
      last_wr_d   = last_wr_q;
      ob_cnt_d    = ob_cnt_q;
      ob0_d       = ob0_q;
      ob1_d       = ob1_q;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         ram_cnt_d  = '0;
         inflight_d = 1'b0;
         last_wr_d  = 1'b0;
         ob_cnt_d   = 2'd0;
      end else begin
         if (wr_fire) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            last_wr_d = 1'b1;
         end
         if (rd_fire) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            last_wr_d = 1'b0;
         end
         inflight_d = rd_fire;

         case ({wr_fire, rd_fire})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
         endcase

         // Returning data lands behind whatever remains after this cycle's pop
         if (inflight_q && pop) begin
            if (ob_cnt_q == 2'd2) begin
               ob0_d = ob1_q;
               ob1_d = bus.ram_rdata;
            end else begin
               ob0_d = bus.ram_rdata;
            end
         end else if (inflight_q) begin
            if (ob_cnt_q == 2'd0) begin
               ob0_d = bus.ram_rdata;
            end else begin
               ob1_d = bus.ram_rdata;
            end
            ob_cnt_d = ob_cnt_q + 2'd1;
         end else if (pop) begin
            ob0_d    = ob1_q;
            ob_cnt_d = ob_cnt_q - 2'd1;
         end
      end

      out_valid_d = (ob_cnt_d != 2'd0);
   end

   // State registers with asynchronous reset
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         last_wr_q   <= 1'b0;
         ob_cnt_q    <= 2'd0;
         ob0_q       <= '0;
         ob1_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_cnt_q   <= ram_cnt_d;
         inflight_q  <= inflight_d;
         last_wr_q   <= last_wr_d;
         ob_cnt_q    <= ob_cnt_d;
         ob0_q       <= ob0_d;
         ob1_q       <= ob1_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_dsd_sp_fifo.sv
// ---------------------------------------------------------------------------
// tb_dsd_sp_fifo
// Directed bench for dsd_sp_fifo with a behavioural single-port RAM and a
// queue holding the words the FIFO is expected to emit, in order.
// ---------------------------------------------------------------------------
module tb_dsd_sp_fifo;

   localparam int AW = 10;
   localparam int DW = 18;

   logic mclk = 1'b0;
   logic rst;
   logic flush;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] expQ [$];
   int            wrCount = 0;
   bit            lastAcc = 1'b0;
   bit            lastPop = 1'b0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always #5 mclk = ~mclk;

   dsd_sp_fifo_if #(.AW(AW), .DW(DW)) bus ();

   dsd_sp_fifo #(.AW(AW), .DW(DW)) dut (
      .mclk  (mclk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   // Single-port RAM: registered read, data valid the cycle after the address
   always @(posedge mclk) begin
      if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs at the falling edge, then track the handshakes
   // that will complete at the next rising edge against the reference queue.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
      logic [DW-1:0] head;
      @(negedge mclk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      flush         = f;
      #1;
      lastAcc = 1'b0;
      lastPop = 1'b0;
      checkOutput("level", 32'(bus.level), 32'(expQ.size()));
      if (f) begin
         checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
         expQ.delete();
         wrCount = 0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            checkOutput("wr_addr", 32'(bus.ram_addr), 32'(wrCount % (1<<AW)));
            checkOutput("ram_wen", 32'(bus.ram_wen), 32'd1);
            expQ.push_back(d);
            wrCount++;
            lastAcc = 1'b1;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_out", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
               head = expQ.pop_front();
               checkOutput("out_data", 32'(bus.out_data), 32'(head));
            end
            lastPop = 1'b1;
         end
      end
   endtask

   task automatic pushWord(input logic [DW-1:0] d, input logic r);
      int n;
      n = 0;
      do begin
         applyStimulus(1'b1, d, r, 1'b0);
         n++;
      end while (!lastAcc && n < 200);
      if (!lastAcc) checkOutput("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitOutput(input string tag, input int expLat);
      int lat;
      lat = 0;
      do begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         lat++;
      end while (!lastPop && lat < 12);
      checkOutput(tag, 32'(lat), 32'(expLat));
   endtask

   task automatic drainAll(input int bound);
      int n;
      n = 0;
      while (expQ.size() > 0 && n < bound) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         n++;
      end
      checkOutput("drain_left", 32'(expQ.size()), 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      checkOutput({tag, "_level"},     32'(bus.level),     32'd0);
      checkOutput({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
      checkOutput({tag, "_ram_wen"},   32'(bus.ram_wen),   32'd0);
      checkOutput({tag, "_ram_addr"},  32'(bus.ram_addr),  32'd0);
   endtask

   initial begin
      int sent;
      int rx;
      int gap;
      int maxGap;
      int altViol;
      bit prevWen;

      // Reset state, with a word offered to show in_ready stays low in reset
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 18'h00005;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      checkResetOutputs("reset");
      bus.in_valid = 1'b0;
      rst          = 1'b0;

      // Five back-to-back words with the consumer stalled
      for (int i = 1; i <= 5; i++) pushWord(DW'(i), 1'b0);
      repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t2_level",     32'(bus.level),     32'd5);
      checkOutput("t2_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t2_out_data",  32'(bus.out_data),  32'h00001);
      drainAll(50);

      // Single word latency into an empty FIFO
      pushWord(18'h2AAAA, 1'b1);
      waitOutput("t3_latency", 3);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t3_level", 32'(bus.level), 32'd0);

      // Fill to capacity with the consumer stalled
      for (int i = 0; i < 1026; i++) pushWord(DW'(i + 'h100), 1'b0);
      applyStimulus(1'b1, 18'h3FFFF, 1'b0, 1'b0);
      checkOutput("t4_full_level",    32'(bus.level),    32'd1026);
      checkOutput("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t4_pop_taken", 32'(lastPop), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t4_in_ready_back", 32'(bus.in_ready), 32'd1);
      drainAll(3000);

      // Concurrent streaming of 4096 words; pointers wrap several times
      sent    = 0;
      rx      = 0;
      gap     = 0;
      maxGap  = 0;
      altViol = 0;
      prevWen = 1'b0;
      for (int c = 0; c < 10000 && rx < 4096; c++) begin
         applyStimulus(sent < 4096, DW'(sent + 'h1000), 1'b1, 1'b0);
         if (lastAcc) sent++;
         if (prevWen && bus.ram_wen) altViol++;
         prevWen = bus.ram_wen;
         if (lastPop) begin
            rx++;
            gap = 0;
         end else if (rx > 0) begin
            gap++;
            if (gap > maxGap) maxGap = gap;
         end
      end
      checkOutput("t5_received",  32'(rx),      32'd4096);
      checkOutput("t5_alternate", 32'(altViol), 32'd0);
      checkOutput("t5_max_gap",   32'(maxGap <= 1), 32'd1);
      drainAll(20);

      // Flush with ten words stored and a read in flight
      for (int i = 0; i < 10; i++) pushWord(DW'(i + 'h500), 1'b0);
      repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t6_level",     32'(bus.level),     32'd0);
      checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd0);
      pushWord(18'h12345, 1'b1);
      waitOutput("t6_latency", 3);
      rx = 0;
      repeat (8) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         if (lastPop) rx++;
      end
      checkOutput("t6_extra_outputs", 32'(rx), 32'd0);

      // Asynchronous reset in the middle of activity
      pushWord(18'h11111, 1'b0);
      pushWord(18'h22222, 1'b0);
      pushWord(18'h33333, 1'b0);
      repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t7_pre_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b1;
      #2;
      rst = 1'b1;
      expQ.delete();
      wrCount = 0;
      #1;
      checkResetOutputs("t7_async");
      repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      pushWord(18'h0ABCD, 1'b1);
      waitOutput("t7_latency", 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
